skolem_checker: RTL and testbench

SKOLEM_CHECKER -- requirements
Module: skolem_checker

---
 rtl/skolem_checker.sv | 113 +++++++++++
 tb/tb_skolem_checker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/skolem_checker.sv
// skolem_checker: exhaustively drives every x-vector to an external Skolem unit and
// checks its y response against the even-parity formula, reporting failures or timeout.
module skolem_checker #(
    parameter int NUM_X   = 6,
    parameter int NUM_Y   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [NUM_X-1:0] req_x,
    input  logic             resp_valid,
    input  logic [NUM_Y-1:0] resp_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [NUM_X:0]   fail_count,
    output logic [NUM_X-1:0] first_fail_x
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]    WC_MAX = CW'(TIMEOUT);
    localparam logic [NUM_X:0]   FC_MAX = {1'b1, {NUM_X{1'b0}}};
    localparam logic [NUM_X-1:0] X_LAST = '1;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, FIN} state_t;
    state_t           state_q;
    logic [NUM_X-1:0] x_q, ffx_q;
    logic [NUM_X:0]   fc_q, fc_d;
    logic [NUM_Y-1:0] y_q;
    logic [CW-1:0]    wc_q, wc_d;
    logic             req_valid_q, busy_q, done_q, pass_q, timeout_q;
    logic             fail, last;
    always_comb begin
        fail = ^{x_q, y_q};
        fc_d = (fail && fc_q != FC_MAX) ? fc_q + 1'b1 : fc_q;
        wc_d = wc_q + 1'b1;
        last = x_q == X_LAST;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            ffx_q       <= '0;
            fc_q        <= '0;
            y_q         <= '0;
            wc_q        <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    fc_q        <= '0;
                    ffx_q       <= '0;
                    pass_q      <= 1'b0;
                    timeout_q   <= 1'b0;
                    x_q         <= '0;
                    req_valid_q <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= ISSUE;
                end
                ISSUE: if (req_ready) begin
                    req_valid_q <= 1'b0;
                    wc_q        <= '0;
                    state_q     <= WAIT;
                end
                WAIT: if (resp_valid) begin
                    y_q     <= resp_y;
                    state_q <= EVAL;
                end else if (wc_d == WC_MAX) begin
                    timeout_q <= 1'b1;
                    pass_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= FIN;
                end else begin
                    wc_q <= wc_d;
                end
                EVAL: begin
                    fc_q <= fc_d;
                    if (fail && fc_q == '0) ffx_q <= x_q;
                    // pass and done are registered on entry to FIN so they are visible during FIN
                    if (last) begin
                        pass_q  <= (fc_d == '0) && !timeout_q;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        x_q         <= x_q + 1'b1;
                        req_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign req_valid    = req_valid_q;
    assign req_x        = x_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign fail_count   = fc_q;
    assign first_fail_x = ffx_q;
endmodule

// File: tb/tb_skolem_checker.sv
// tb_skolem_checker: scoreboard bench; a responder models the Skolem unit per run mode,
// and a monitor compares each done result against the queued expectation.
module tb_skolem_checker;
    logic       clk = 0, rst_n = 0, start = 0, req_ready = 1, resp_valid = 0;
    logic [1:0] resp_y = '0;
    logic       req_valid, busy, done, pass, timeout;
    logic [5:0] req_x, first_fail_x;
    logic [6:0] fail_count;

    skolem_checker #(.NUM_X(6), .NUM_Y(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .resp_valid(resp_valid), .resp_y(resp_y), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .fail_count(fail_count), .first_fail_x(first_fail_x)
    );

    always #5 clk = ~clk;

    typedef struct { int p; int t; int fc; int ffx; int hs; int lat; } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_err = 0, cyc = 0, cyc0 = 0, hs_cnt = 0, hs0 = 0, mode = 0, stall_left = 0;
    bit stall_en = 0, stall_done = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(int p, int t, int fc, int ffx, int hs, int lat);
        exp_t e;
        e.p = p; e.t = t; e.fc = fc; e.ffx = ffx; e.hs = hs; e.lat = lat;
        return e;
    endfunction

    function automatic logic [1:0] good_y(logic [5:0] x);
        return {x[0], x[0] ^ (^x)};
    endfunction

    task automatic outputs_zero(string tag);
        check({tag, "_req_valid"}, req_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_fail_count"}, fail_count, 0);
        check({tag, "_first_fail_x"}, first_fail_x, 0);
        check({tag, "_req_x"}, req_x, 0);
    endtask

    // modes: 0/3 correct, 1 all-zero, 2 silent after x=5, 4 y0 inverted at x=15h,2Ah
    initial begin : responder
        logic       hs;
        logic [5:0] hx;
        forever begin
            @(negedge clk);
            if (stall_left > 0) begin
                check("stall_req_valid", req_valid, 1);
                check("stall_req_x", req_x, 32'h0A);
                stall_left--;
                if (stall_left == 0) req_ready = 1;
            end else if (stall_en && !stall_done && req_valid && req_x == 6'h0A) begin
                req_ready  = 0;
                stall_left = 5;
                stall_done = 1;
            end
            hs = req_valid && req_ready;
            hx = req_x;
            @(posedge clk);
            #1;
            resp_valid = 0;
            if (hs && !(mode == 2 && hx > 6'h05)) begin
                resp_valid = 1;
                resp_y = mode == 1 ? 2'b00 :
                         good_y(hx) ^ ((mode == 4 && (hx == 6'h15 || hx == 6'h2A)) ? 2'b01 : 2'b00);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    e = q.pop_front();
                    check("pass", pass, e.p);
                    check("timeout", timeout, e.t);
                    check("fail_count", fail_count, e.fc);
                    check("first_fail_x", first_fail_x, e.ffx);
                    check("handshakes", hs_cnt - hs0, e.hs);
                    check("done_cycle", cyc - cyc0 + 1, e.lat);
                    check("busy_in_fin", busy, 1);
                end
                @(negedge clk);
                check("done_width", done, 0);
            end
        end
    end

    task automatic run(int m, bit stall, bit poke, exp_t e);
        mode = m;
        stall_en = stall;
        stall_done = 0;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1;
        hs0 = hs_cnt;
        @(posedge clk); #1;
        start = 0;
        cyc0 = cyc;
        for (int i = 0; i < 600 && q.size() != 0; i++) begin
            @(posedge clk); #1;
            start = poke && (i == 40 || i == 100);
        end
        start = 0;
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_mode%0d: got no done expected done within 600 cycles", m);
            q.delete();
        end
        repeat (3) @(negedge clk);
        check("hold_pass", pass, e.p);
        check("hold_timeout", timeout, e.t);
        check("hold_fail_count", fail_count, e.fc);
        check("hold_first_fail_x", first_fail_x, e.ffx);
        check("idle_busy", busy, 0);
    endtask

    initial begin : main
        bit found;
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst_n = 1;
        run(0, 0, 0, mk(1, 0, 0, 0, 64, 193));
        run(1, 0, 0, mk(0, 0, 32, 6'h01, 64, 193));
        run(2, 0, 0, mk(0, 1, 0, 0, 7, 36));
        run(3, 1, 0, mk(1, 0, 0, 0, 64, 198));
        run(4, 0, 1, mk(0, 0, 2, 6'h15, 64, 193));
        mode = 0;
        stall_en = 0;
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            found = req_valid && req_x == 6'h20;
        end
        check("reach_x20", found, 1);
        rst_n = 0;
        #1;
        outputs_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (10) @(negedge clk);
        check("post_reset_busy", busy, 0);
        run(0, 0, 0, mk(1, 0, 0, 0, 64, 193));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
